// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path and the burst sequencer.
// Holds the default frame/address/length widths, the header field layout
// derived from them, and the sequencer state encoding.
package spi_pkg;

    // Default geometry; the receiver and the sequencer must agree on SPI_N.
    localparam int SPI_N  = 16;
    localparam int BUS_AW = 7;
    localparam int LEN_W  = 8;

    // Header layout: flag bit on top, address field directly below it,
    // length field in the low bits.
    localparam int HDR_FLAG_BIT = SPI_N - 1;
    localparam int HDR_ADDR_MSB = SPI_N - 2;
    localparam int HDR_ADDR_LSB = SPI_N - 1 - BUS_AW;
    localparam int HDR_LEN_MSB  = LEN_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_WRITE = 2'd2
    } burst_state_e;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Register-bus write channel between the burst sequencer and the
// configuration register bank.
//   valid : write request valid (master)
//   addr  : write address (master)
//   data  : write data (master)
//   ready : slave accepts when valid & ready
interface spi_burst_ctrl_if #(
    parameter int N  = spi_pkg::SPI_N,
    parameter int AW = spi_pkg::BUS_AW
);
    logic          valid;
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
    logic          ready;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with rise/fall detection for a slow asynchronous
// control level (e.g. SPI chip select).
//   clk, rst : system clock, synchronous active-high reset
//   async_in : asynchronous input level
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer behind the SPI receiver. The first frame of a transaction
// is a header (flag, start address, word count); each following frame is
// written to an auto-incremented address on the register bus.
//   clk, rst    : system clock, synchronous active-high reset
//   rx_data     : receiver word, valid while rx_end is high
//   rx_end      : receiver end-of-frame level
//   ss          : raw chip select (active-low, asynchronous)
//   bus         : register write channel (master side)
//   busy        : sequencer not idle
//   done        : pulse the cycle after the last burst word is accepted
//   err_len     : sticky, header with zero length
//   err_ovr     : sticky, frame arrived while a write was still pending
//   err_abort   : sticky, chip select released with words outstanding
//   clr_err     : clears the sticky errors
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int N  = SPI_N,
    parameter int AW = BUS_AW,
    parameter int LW = LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     rx_data,
    input  logic             rx_end,
    input  logic             ss,
    spi_burst_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_ovr,
    output logic             err_abort,
    input  logic             clr_err
);

    localparam int HDR_BIT = N - 1;

    burst_state_e  state_r, state_n_s;
    logic          valid_r, valid_n_s;
    logic [AW-1:0] addr_r, addr_n_s;
    logic [N-1:0]  data_r, data_n_s;
    logic [LW-1:0] rem_r, rem_n_s;
    logic          done_r, done_n_s;
    logic          abort_pend_r, abort_pend_n_s;
    logic          rx_end_d_r;
    logic          err_len_r, err_ovr_r, err_abort_r;
    logic          set_len_s, set_ovr_s, set_abort_s;
    logic          fstb_s, ss_rise_s, handshake_s;
    logic [AW-1:0] hdr_addr_s;
    logic [LW-1:0] hdr_len_s;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ss),
        .rise     (ss_rise_s),
        .fall     ()
    );

    assign fstb_s      = rx_end & ~rx_end_d_r;
    assign handshake_s = valid_r & bus.ready;
    assign hdr_addr_s  = rx_data[N-2 -: AW];
    assign hdr_len_s   = rx_data[LW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state and datapath-next logic for the burst sequencer.
    always_comb begin
        state_n_s      = state_r;
        valid_n_s      = valid_r;
        addr_n_s       = addr_r;
        data_n_s       = data_r;
        rem_n_s        = rem_r;
        done_n_s       = 1'b0;
        abort_pend_n_s = 1'b0;
        set_len_s      = 1'b0;
        set_ovr_s      = 1'b0;
        set_abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fstb_s && rx_data[HDR_BIT]) begin
                    if (hdr_len_s != {LW{1'b0}}) begin
                        addr_n_s  = hdr_addr_s;
                        rem_n_s   = hdr_len_s;
                        state_n_s = ST_DATA;
                    end else begin
                        set_len_s = 1'b1;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                // Chip-select release beats a coincident frame.
                if (ss_rise_s) begin
                    set_abort_s = 1'b1;
                    rem_n_s     = {LW{1'b0}};
                    state_n_s   = ST_IDLE;
                end else if (fstb_s) begin
                    data_n_s  = rx_data;
                    valid_n_s = 1'b1;
                    state_n_s = ST_WRITE;
                end else begin
                    state_n_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                set_ovr_s = fstb_s;
                if (handshake_s) begin
                    valid_n_s = 1'b0;
                    addr_n_s  = addr_r + {{(AW-1){1'b0}}, 1'b1};
                    rem_n_s   = rem_r - {{(LW-1){1'b0}}, 1'b1};
                    if (rem_r == {{(LW-1){1'b0}}, 1'b1}) begin
                        done_n_s  = 1'b1;
                        state_n_s = ST_IDLE;
                    end else if (ss_rise_s || abort_pend_r) begin
                        // Release seen during the write: finish it, then abort.
                        set_abort_s = 1'b1;
                        rem_n_s     = {LW{1'b0}};
                        state_n_s   = ST_IDLE;
                    end else begin
                        state_n_s = ST_DATA;
                    end
                end else begin
                    abort_pend_n_s = abort_pend_r | ss_rise_s;
                end
            end
            default: begin
                valid_n_s = 1'b0;
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Datapath, edge history and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r      <= 1'b0;
            addr_r       <= {AW{1'b0}};
            data_r       <= {N{1'b0}};
            rem_r        <= {LW{1'b0}};
            done_r       <= 1'b0;
            abort_pend_r <= 1'b0;
            rx_end_d_r   <= 1'b0;
            err_len_r    <= 1'b0;
            err_ovr_r    <= 1'b0;
            err_abort_r  <= 1'b0;
        end else begin
            valid_r      <= valid_n_s;
            addr_r       <= addr_n_s;
            data_r       <= data_n_s;
            rem_r        <= rem_n_s;
            done_r       <= done_n_s;
            abort_pend_r <= abort_pend_n_s;
            rx_end_d_r   <= rx_end;
            // A new error event outranks a simultaneous clear.
            err_len_r    <= set_len_s   | (err_len_r   & ~clr_err);
            err_ovr_r    <= set_ovr_s   | (err_ovr_r   & ~clr_err);
            err_abort_r  <= set_abort_s | (err_abort_r & ~clr_err);
        end
    end

    assign bus.valid = valid_r;
    assign bus.addr  = addr_r;
    assign bus.data  = data_r;
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign err_len   = err_len_r;
    assign err_ovr   = err_ovr_r;
    assign err_abort = err_abort_r;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
module tb_spi_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rx_data;
    logic        rx_end;
    logic        ss;
    logic        busy, done, err_len, err_ovr, err_abort;
    logic        clr_err;
    logic        rand_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  got_addr[$];
    logic [15:0] got_data[$];
    logic [6:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    int          done_cnt;
    int          valid_cnt;

    spi_burst_ctrl_if #(.N(16), .AW(7)) bus ();

    spi_burst_ctrl #(.N(16), .AW(7), .LW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_end    (rx_end),
        .ss        (ss),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len),
        .err_ovr   (err_ovr),
        .err_abort (err_abort),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    // Bus monitor: records accepted writes and done pulses (sampled on falling edge).
    initial begin
        forever begin
            @(negedge clk);
            if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                got_addr.push_back(bus.addr);
                got_data.push_back(bus.data);
            end
            if (bus.valid === 1'b1) valid_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    // Random ready generator, active only when rand_ready is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [15:0] hdr(input int a, input int l);
        logic [6:0] a7;
        logic [7:0] l8;
        a7 = a[6:0];
        l8 = l[7:0];
        return {1'b1, a7, l8};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
        done_cnt = 0; valid_cnt = 0;
    endtask

    // Model of a burst: expected writes at start address + i, wrapping at 128.
    task automatic model_burst(input int a, input logic [15:0] d[$]);
        foreach (d[i]) begin
            exp_addr.push_back(7'((a + i) % 128));
            exp_data.push_back(d[i]);
        end
    endtask

    task automatic send_frame(input logic [15:0] w);
        rx_end = 1'b0;
        cyc(2);
        rx_data = w;
        rx_end  = 1'b1;
        cyc(3);
    endtask

    task automatic begin_txn();
        ss = 1'b0;
        cyc(4);
    endtask

    task automatic end_txn();
        ss = 1'b1;
        cyc(6);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(1);
    endtask

    task automatic wait_no_valid();
        int c = 0;
        while (bus.valid === 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        cyc(1);
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_no_valid: valid=%b still high after %0d cycles, required 0", bus.valid, c);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy !== 1'b0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, c);
        end
    endtask

    task automatic check_writes(input string name);
        n_checks++;
        if (got_addr.size() !== exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", name, got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                n_checks++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got (%0d,%h) required (%0d,%h)", name, i,
                             got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic check_flags(input string name, input logic b, input logic l, input logic o, input logic a);
        n_checks++;
        if ({busy, err_len, err_ovr, err_abort} !== {b, l, o, a}) begin
            n_fail++;
            $display("FAIL %s flags busy/len/ovr/abort: got %b%b%b%b required %b%b%b%b", name,
                     busy, err_len, err_ovr, err_abort, b, l, o, a);
        end
    endtask

    task automatic check_done(input string name, input int n);
        n_checks++;
        if (done_cnt !== n) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d required %0d", name, done_cnt, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.valid, bus.addr, bus.data, done} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_bus: valid=%b addr=%0d data=%h done=%b required all 0",
                     bus.valid, bus.addr, bus.data, done);
        end
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic();
        logic [15:0] d[$];
        clear_log();
        bus.ready = 1'b1;
        d = '{16'h1111, 16'h2222, 16'h3333};
        model_burst(5, d);
        begin_txn();
        send_frame(16'h8503);
        foreach (d[i]) begin
            send_frame(d[i]);
            wait_no_valid();
        end
        end_txn();
        wait_idle();
        check_writes("basic");
        check_done("basic", 1);
        check_flags("basic", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [15:0] d[$];
        clear_log();
        d = '{16'hAAAA, 16'hBBBB};
        model_burst(127, d);
        begin_txn();
        send_frame(hdr(127, 2));
        foreach (d[i]) begin
            send_frame(d[i]);
            wait_no_valid();
        end
        end_txn();
        wait_idle();
        check_writes("wrap");
        check_done("wrap", 1);
        check_flags("wrap", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero();
        clear_log();
        begin_txn();
        send_frame(16'h8A00);
        cyc(4);
        end_txn();
        n_checks++;
        if (valid_cnt !== 0) begin
            n_fail++;
            $display("FAIL len_zero_valid: valid high %0d cycles, required 0", valid_cnt);
        end
        check_flags("len_zero", 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_clr();
        check_flags("len_zero_clr", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        int unstable = 0;
        int a;
        logic [15:0] d1, d2, d3;
        logic [15:0] d[$];
        clear_log();
        a  = $urandom_range(0, 127);
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        d3 = 16'($urandom);
        bus.ready = 1'b0;
        begin_txn();
        send_frame(hdr(a, 2));
        send_frame(d1);
        for (int i = 0; i < 40; i++) begin
            if (i == 15) send_frame(d2);
            @(negedge clk);
            if (bus.valid !== 1'b1 || bus.addr !== 7'(a) || bus.data !== d1) unstable++;
            cyc(1);
        end
        n_checks++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL overrun_hold: %0d unstable cycles, required 0", unstable);
        end
        check_flags("overrun_stall", 1'b1, 1'b0, 1'b1, 1'b0);
        bus.ready = 1'b1;
        cyc(6);
        check_done("overrun_mid", 0);
        check_flags("overrun_mid", 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(d3);
        wait_no_valid();
        end_txn();
        wait_idle();
        d = '{d1, d3};
        model_burst(a, d);
        check_writes("overrun");
        check_done("overrun", 1);
        pulse_clr();
    endtask

    task automatic test_abort();
        logic [15:0] d[$];
        clear_log();
        bus.ready = 1'b1;
        d = '{16'h0F0F, 16'hF0F0};
        model_burst(20, d);
        begin_txn();
        send_frame(hdr(20, 4));
        foreach (d[i]) begin
            send_frame(d[i]);
            wait_no_valid();
        end
        end_txn();
        check_writes("abort");
        check_done("abort", 0);
        check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_clr();
        clear_log();
        d = '{16'h5A5A};
        model_burst(90, d);
        begin_txn();
        send_frame(hdr(90, 1));
        send_frame(d[0]);
        wait_no_valid();
        end_txn();
        wait_idle();
        check_writes("after_abort");
        check_done("after_abort", 1);
        check_flags("after_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        clear_log();
        rand_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            int a, l;
            logic [15:0] d[$];
            a = $urandom_range(0, 127);
            l = $urandom_range(1, 6);
            d.delete();
            for (int i = 0; i < l; i++) d.push_back(16'($urandom));
            model_burst(a, d);
            begin_txn();
            send_frame(hdr(a, l));
            foreach (d[i]) begin
                send_frame(d[i]);
                wait_no_valid();
            end
            end_txn();
            wait_idle();
        end
        rand_ready = 1'b0;
        bus.ready = 1'b1;
        check_writes("random");
        check_done("random", 8);
        check_flags("random", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid();
        clear_log();
        begin_txn();
        send_frame(16'h8000);
        end_txn();
        bus.ready = 1'b0;
        begin_txn();
        send_frame(hdr(33, 2));
        send_frame(16'hC0DE);
        n_checks++;
        if (bus.valid !== 1'b1 || err_len !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: valid=%b err_len=%b required 1 1", bus.valid, err_len);
        end
        rst = 1'b1;
        cyc(1);
        n_checks++;
        if ({bus.valid, bus.addr, bus.data, done} !== 25'd0) begin
            n_fail++;
            $display("FAIL rst_mid_bus: valid=%b addr=%0d data=%h done=%b required all 0",
                     bus.valid, bus.addr, bus.data, done);
        end
        check_flags("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.ready = 1'b1;
        clear_log();
        send_frame(16'h1234);
        cyc(10);
        end_txn();
        n_checks++;
        if (valid_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_nonheader: valid high %0d cycles, required 0", valid_cnt);
        end
        check_flags("rst_nonheader", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        ss         = 1'b1;
        rx_end     = 1'b0;
        rx_data    = 16'h0000;
        clr_err    = 1'b0;
        rand_ready = 1'b0;
        bus.ready  = 1'b0;
        done_cnt   = 0;
        valid_cnt  = 0;
        cyc(3);
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_overrun();
        test_abort();
        test_random();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
